axi4_lite_master: RTL and testbench
===================================

Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite master.
- Converts a simple command/response interface into AXI4-Lite read and write bursts of length 1.
- Sits directly upstream of axi4_slave: the CPU/testbench-side driver issues commands, and this block drives AW/W/B/AR/R.
- Data is 32-bit with byte strobes; the AXI response code is returned to the requester.

Parameters:
- ADDR_W, 32, address width of cmd_addr / AWADDR / ARADDR
- TIMEOUT_CYCLES, 256, wait-state limit; used only when AXI_MST_TIMEOUT_EN is defined

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or timeout code
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master side; widths ADDR_W/32/4/2/1.

Behaviour:
- Clock ACLK; reset ARESETn, asynchronous, active-low.
- Reset values: state=IDLE; all VALID/READY outputs 0; rsp_valid 0; rsp_rdata, rsp_resp, rsp_write, AWADDR, ARADDR, WDATA, WSTRB all 0.
- All outputs are registered. cmd_ready is 1 exactly in IDLE.

FSM states: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - On cmd handshake, latch addr/data/strb/write.
  - Write: go to WR with AWVALID=1 and WVALID=1 the next cycle.
  - Read: go to RD_A with ARVALID=1 the next cycle.
- WR:
  - AW and W are tracked by independent done flags.
  - Each VALID drops the cycle after its own handshake.
  - Both channels may complete in the same cycle or in either order.
  - When both are done, go to WR_B.
- WR_B:
  - BREADY=1.
  - On BVALID&&BREADY, capture BRESP and go to RSP.
  - BVALID may rise before WR_B is entered; the slave holds it, so no B is lost.
- RD_A: ARVALID held until ARVALID&&ARREADY, then go to RD_R.
- RD_R:
  - RREADY=1.
  - On handshake, capture RDATA and RRESP and go to RSP.
  - RVALID rising in the same cycle as ARREADY is legal.
- RSP:
  - rsp_valid=1 with stable fields.
  - On rsp_ready, go to IDLE.
  - cmd_ready returns the cycle after the response handshake.
- Minimum latency with a zero-wait slave:
  - Write: cmd handshake to rsp_valid in 4 cycles.
  - Read: cmd handshake to rsp_valid in 4 cycles.

AXI rules:
- No VALID depends combinationally on READY.
- VALID is never withdrawn before its handshake, except on timeout.
- Payload is stable while VALID is high.

Other rules:
- cmd_addr is passed unaligned; the slave decodes [9:2].
- rsp_rdata is cleared to 0 on write responses.
- Reset mid-transaction: everything returns to reset values immediately. No response is emitted for the aborted command.

Optional Feature:
- Macro AXI_MST_TIMEOUT_EN.
- Defined:
  - A counter is cleared on every state entry and increments in WR, WR_B, RD_A and RD_R.
  - On reaching TIMEOUT_CYCLES-1 with no handshake, all AXI VALID/READY outputs drop and the FSM goes to RSP with rsp_resp=2'b11 (DECERR) and rsp_rdata=0.
  - This is a debug escape and is known to break protocol with a hung slave.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package axi4_lite_pkg holds:
  - typedef resp_t (2-bit) with constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - enum mst_state_t
- No sub-module is needed; a single FSM module.

Test Plan:
- Write 0x0000_0010 with data 0xDEAD_BEEF, strb 4'hF, against axi4_slave -> one AW and one W handshake, B OKAY; rsp_valid 4 cycles after cmd with rsp_resp=0, rsp_write=1.
- Read back 0x10 -> rsp_rdata=0xDEAD_BEEF, rsp_resp=0; ARVALID high for exactly 1 cycle after ARREADY.
- Write data 0x1122_3344 with strb 4'b0101 to 0x10, then read -> 0xDE22_BE44.
- Stalled slave model with AWREADY delayed 5 cycles, WREADY immediate, BVALID after both -> WVALID drops after 1 cycle, AWVALID held 5 cycles, single response.
- rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready=0 throughout; next cmd accepted the cycle after the response handshake.
- Reset pulse while in WR_B -> all outputs at reset values next edge, no rsp_valid. With AXI_MST_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that never asserts ARREADY -> rsp_resp=2'b11 after 8 cycles in RD_A.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master: response codes and FSM state encoding.
package axi4_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_R = 3'd4,
    RSP  = 3'd5
  } mst_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transfer, one response out.
// Optional wait-state timeout enabled by defining AXI_MST_TIMEOUT_EN.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  mst_state_t state, state_n;
  logic aw_done, w_done, aw_done_n, w_done_n;
  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic tmo_hit, tmo;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign b_hs   = BVALID && BREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign r_hs   = RVALID && RREADY;

`ifdef AXI_MST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tcnt;
  logic             is_wait;

  assign is_wait = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);
  assign tmo_hit = is_wait && (tcnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // restarts on every state change so each wait phase gets the full budget
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn)               tcnt <= '0;
    else if (state_n != state)  tcnt <= '0;
    else if (is_wait)           tcnt <= tcnt + 1'b1;
`else
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        if (cmd_hs) state_n = cmd_write ? WR : RD_A;
      end
      WR: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if (aw_done_n && w_done_n) state_n = WR_B;
      end
      WR_B:    if (b_hs)      state_n = RSP;
      RD_A:    if (ar_hs)     state_n = RD_R;
      RD_R:    if (r_hs)      state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo_hit && state_n == state) begin
      state_n = RSP;
      tmo     = 1'b1;
    end
  end

  // every output is a register derived from the next state, so no VALID
  // ever follows a READY combinationally
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
    end else begin
      state     <= state_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      cmd_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RSP);
      AWVALID   <= (state_n == WR) && !aw_done_n;
      WVALID    <= (state_n == WR) && !w_done_n;
      BREADY    <= (state_n == WR_B);
      ARVALID   <= (state_n == RD_A);
      RREADY    <= (state_n == RD_R);
      if (cmd_hs) begin
        rsp_write <= cmd_write;
        if (cmd_write) begin
          AWADDR <= cmd_addr;
          WDATA  <= cmd_wdata;
          WSTRB  <= cmd_wstrb;
        end else begin
          ARADDR <= cmd_addr;
        end
      end
      if (state_n == RSP && state != RSP) begin
        if (tmo) begin
          rsp_resp  <= RESP_DECERR;
          rsp_rdata <= '0;
        end else if (state == WR_B) begin
          rsp_resp  <= BRESP;
          rsp_rdata <= '0;
        end else begin
          rsp_resp  <= RRESP;
          rsp_rdata <= RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a small behavioural AXI4-Lite slave.
module tb_axi4_lite_master;
  localparam int AW = 32;

  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4_lite_master #(.ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // slave: registered one-shot READY pulses, B/R one cycle after handshake,
  // SLVERR above 0x3FF; knobs for AW stall, always-ready W, B hold, AR hang
  int   aw_delay = 0;
  logic w_imm = 0, b_hold = 0, ar_hang = 0;
  logic [31:0] mem [256];
  logic aw_got, w_got;
  int   aw_wait;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge ACLK or negedge ARESETn) begin
    logic awg, wg;
    if (!ARESETn) begin
      AWREADY <= 0; WREADY <= 0; ARREADY <= 0; BVALID <= 0; RVALID <= 0;
      BRESP <= 0; RRESP <= 0; RDATA <= 0; aw_got <= 0; w_got <= 0; aw_wait <= 0;
    end else begin
      awg = aw_got | (AWVALID && AWREADY);
      wg  = w_got  | (WVALID && WREADY);
      AWREADY <= AWVALID && !AWREADY && !aw_got && (aw_wait >= aw_delay);
      if (AWVALID && AWREADY) aw_wait <= 0;
      else if (AWVALID && !AWREADY && !aw_got && aw_wait < aw_delay) aw_wait <= aw_wait + 1;
      WREADY  <= w_imm ? 1'b1 : (WVALID && !WREADY && !w_got);
      ARREADY <= !ar_hang && ARVALID && !ARREADY;
      if (BVALID && BREADY) BVALID <= 0;
      if (awg && wg) begin
        if (AWADDR < 32'h400)
          for (int b = 0; b < 4; b++)
            if (WSTRB[b]) mem[AWADDR[9:2]][8*b +: 8] <= WDATA[8*b +: 8];
        BRESP <= (AWADDR < 32'h400) ? 2'b00 : 2'b10;
        if (!b_hold) BVALID <= 1;
        aw_got <= 0; w_got <= 0;
      end else begin
        aw_got <= awg; w_got <= wg;
      end
      if (RVALID && RREADY) RVALID <= 0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1;
        RDATA  <= (ARADDR < 32'h400) ? mem[ARADDR[9:2]] : 32'h0;
        RRESP  <= (ARADDR < 32'h400) ? 2'b00 : 2'b10;
      end
    end
  end

  int awv_c = 0, wv_c = 0, arv_c = 0, awh_c = 0, wh_c = 0, bh_c = 0, arh_c = 0;
  always @(posedge ACLK) begin
    if (AWVALID) awv_c <= awv_c + 1;
    if (WVALID) wv_c <= wv_c + 1;
    if (ARVALID) arv_c <= arv_c + 1;
    if (AWVALID && AWREADY) awh_c <= awh_c + 1;
    if (WVALID && WREADY) wh_c <= wh_c + 1;
    if (BVALID && BREADY) bh_c <= bh_c + 1;
    if (ARVALID && ARREADY) arh_c <= arh_c + 1;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic outs_nonzero();
    return |{cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, AWADDR, AWVALID, WDATA,
             WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY};
  endfunction

  // lat = negedges from the handshake cycle until rsp_valid is seen
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ack,
                        output logic [31:0] rd, output logic [1:0] rr,
                        output logic rw, output int lat);
    int n = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    if (!cmd_ready) chk("cmd_accept_timeout", cmd_ready, 1);
    lat = 0;
    @(negedge ACLK); cmd_valid = 0; lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge ACLK); lat++; end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
    if (ack) begin
      rsp_ready = 1; @(negedge ACLK); rsp_ready = 0;
    end
  endtask

  typedef struct {
    logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s;
    logic [31:0] er; logic [1:0] ers;
  } vec_t;

  initial begin
    vec_t tbl[10];
    logic [31:0] rd; logic [1:0] rr; logic rw; int lat;
    logic [34:0] cap; logic stable, seen; int s0, s1, s2, s3, n;

    tbl[0] = '{1, 32'h10,  32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    tbl[1] = '{0, 32'h10,  32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    tbl[2] = '{1, 32'h10,  32'h1122_3344, 4'h5, 32'h0,         2'b00};
    tbl[3] = '{0, 32'h10,  32'h0,         4'h0, 32'hDE22_BE44, 2'b00};
    tbl[4] = '{1, 32'h13,  32'hAABB_CCDD, 4'h8, 32'h0,         2'b00};
    tbl[5] = '{0, 32'h12,  32'h0,         4'h0, 32'hAA22_BE44, 2'b00};
    tbl[6] = '{1, 32'h400, 32'h5555_5555, 4'hF, 32'h0,         2'b10};
    tbl[7] = '{0, 32'h404, 32'h0,         4'h0, 32'h0,         2'b10};
    tbl[8] = '{1, 32'h3FC, 32'hFFFF_FFFF, 4'h3, 32'h0,         2'b00};
    tbl[9] = '{0, 32'h3FC, 32'h0,         4'h0, 32'h0000_FFFF, 2'b00};

    #1 chk("reset_outputs", outs_nonzero(), 0);
    @(negedge ACLK); @(negedge ACLK); ARESETn = 1;
    @(negedge ACLK); @(negedge ACLK);
    chk("idle_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 10; i++) begin
      s0 = awh_c; s1 = wh_c; s2 = bh_c; s3 = arh_c;
      do_cmd(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, 1, rd, rr, rw, lat);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("v%0d_resp", i), rr, tbl[i].ers);
      chk($sformatf("v%0d_write", i), rw, tbl[i].w);
      chk($sformatf("v%0d_latency", i), lat, 4);
      if (tbl[i].w) begin
        chk($sformatf("v%0d_aw_hs", i), awh_c - s0, 1);
        chk($sformatf("v%0d_w_hs", i), wh_c - s1, 1);
        chk($sformatf("v%0d_b_hs", i), bh_c - s2, 1);
      end else begin
        chk($sformatf("v%0d_ar_hs", i), arh_c - s3, 1);
      end
    end

    // AW stalled, W always ready: W finishes first, AW held until its handshake
    aw_delay = 3; w_imm = 1;
    s0 = awv_c; s1 = wv_c; s2 = bh_c;
    do_cmd(1, 32'h20, 32'h0BAD_F00D, 4'hF, 1, rd, rr, rw, lat);
    chk("stall_awvalid_cycles", awv_c - s0, 5);
    chk("stall_wvalid_cycles", wv_c - s1, 1);
    chk("stall_b_hs", bh_c - s2, 1);
    chk("stall_resp", rr, 2'b00);
    aw_delay = 0; w_imm = 0;
    do_cmd(0, 32'h20, 32'h0, 4'h0, 1, rd, rr, rw, lat);
    chk("stall_readback", rd, 32'h0BAD_F00D);

    // response back-pressure
    do_cmd(0, 32'h10, 32'h0, 4'h0, 0, rd, rr, rw, lat);
    cap = {rsp_write, rsp_rdata, rsp_resp}; stable = 1;
    repeat (10) begin
      @(negedge ACLK);
      if (!rsp_valid || cmd_ready || {rsp_write, rsp_rdata, rsp_resp} !== cap) stable = 0;
    end
    chk("rsp_hold_stable", stable, 1);
    chk("rsp_hold_rdata", rsp_rdata, 32'hAA22_BE44);
    rsp_ready = 1; @(negedge ACLK); rsp_ready = 0;
    chk("cmd_ready_after_rsp", cmd_ready, 1);
    chk("rsp_valid_after_rsp", rsp_valid, 0);

    // reset while waiting in WR_B
    b_hold = 1; n = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    @(negedge ACLK); cmd_valid = 0;
    while (!BREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("wr_b_reached", BREADY, 1);
    ARESETn = 0;
    #1 chk("midreset_outputs", outs_nonzero(), 0);
    @(negedge ACLK); @(negedge ACLK);
    ARESETn = 1; b_hold = 0; seen = 0;
    repeat (5) begin @(negedge ACLK); if (rsp_valid) seen = 1; end
    chk("no_rsp_after_reset", seen, 0);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    do_cmd(0, 32'h10, 32'h0, 4'h0, 1, rd, rr, rw, lat);
    chk("post_reset_read", rd, 32'hAA22_BE44);

`ifdef AXI_MST_TIMEOUT_EN
    ar_hang = 1; s0 = arv_c;
    do_cmd(0, 32'h10, 32'h0, 4'h0, 0, rd, rr, rw, lat);
    chk("tmo_resp", rr, 2'b11);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_arvalid_cycles", arv_c - s0, 8);
    chk("tmo_arvalid_dropped", ARVALID, 0);
    rsp_ready = 1; @(negedge ACLK); rsp_ready = 0; ar_hang = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
